// File: rtl/ifmap_window_gen.sv
// ifmap_window_gen: K-byte horizontal sliding window over an ifmap byte stream.
// Tracks column/row position and flags the last window of a row (out_last)
// and the completion of a frame (frame_done).
// Optional build macro: IFMAP_ZERO_PAD_EN enables left zero padding, so every
// accepted byte emits a window (ROW_W windows per row instead of ROW_W-K+1).
module ifmap_window_gen #(
  parameter int K     = 3,
  parameter int ROW_W = 8,
  parameter int ROWS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_ifmap,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*K-1:0] out_window,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           frame_done
);

  localparam int CW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [K-1:0][7:0] sr;    // lane K-1 newest, lane 0 oldest
  logic [K-1:0][7:0] nxt;   // window after shifting in the current byte
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              out_row_last;  // held window belongs to row ROWS-1
  logic              accept, emit, col_end, row_end;

  // No skid buffer: a new byte is taken only when the output slot is free or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(ROW_W - 1));
  assign row_end  = (row == RW'(ROWS - 1));

`ifdef IFMAP_ZERO_PAD_EN
  assign emit = 1'b1;
`else
  assign emit = (col >= CW'(K - 1));
`endif

  // Per-lane next value: newest lane takes the input, the rest shift toward lane 0.
  for (genvar i = 0; i < K; i++) begin : g_lane
    if (i == K - 1) begin : g_newest
      assign nxt[i] = in_ifmap;
    end else begin : g_older
`ifdef IFMAP_ZERO_PAD_EN
      // Row start: older lanes are the left padding.
      assign nxt[i] = (col == '0) ? 8'h00 : sr[i+1];
`else
      // Stale lanes are flushed by the K-1 priming bytes, so no clear is needed.
      assign nxt[i] = sr[i+1];
`endif
    end
  end

  // Shift register and column/row position advance on every accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      col <= '0;
      row <= '0;
    end else if (accept) begin
      sr <= nxt;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output slot: load on emit (replacing a window drained in the same edge), clear on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_window   <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_row_last <= 1'b0;
    end else if (accept && emit) begin
      out_window   <= nxt;
      out_valid    <= 1'b1;
      out_last     <= col_end;
      out_row_last <= row_end;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Frame completion pulse, one cycle after the final window of the frame is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= out_valid && out_ready && out_last && out_row_last;
  end

endmodule

// File: tb/tb_ifmap_window_gen.sv
// Directed + randomized-handshake bench for ifmap_window_gen (K=3, ROW_W=4, ROWS=2).
module tb_ifmap_window_gen;
  localparam int K = 3, ROW_W = 4, ROWS = 2;
`ifdef IFMAP_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 0, rst = 1;
  logic [7:0]  in_ifmap = 0;
  logic        in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, out_last, frame_done;
  logic [23:0] out_window;

  int checks = 0, passes = 0;

  ifmap_window_gen #(.K(K), .ROW_W(ROW_W), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .in_ifmap(in_ifmap), .in_valid(in_valid),
    .in_ready(in_ready), .out_window(out_window), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done));

  always #5 clk = ~clk;

  // Handshake monitor, sampled on the falling edge.
  logic [23:0] win_q[$];
  logic        last_q[$];
  int          fd_cnt = 0;
  logic [23:0] fd_after_win = 0, prev_hs_win = 0;
  logic        prev_hs = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        fd_cnt++;
        fd_after_win = prev_hs ? prev_hs_win : 24'hxxxxxx;
      end
      prev_hs = out_valid && out_ready;
      if (out_valid && out_ready) begin
        prev_hs_win = out_window;
        win_q.push_back(out_window);
        last_q.push_back(out_last);
      end
    end
  end

  task automatic do_reset();
    in_valid = 0; out_ready = 1; rst = 1;
    @(posedge clk); #1; rst = 0;
    win_q.delete(); last_q.delete(); fd_cnt = 0; prev_hs = 0;
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] b);
    int guard = 0;
    in_ifmap = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %h", b);
    end
    @(posedge clk); #1; in_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; #2;
    checks++; if (out_valid !== 0 || out_last !== 0 || frame_done !== 0) $display("FAIL reset_flags: v=%b l=%b fd=%b want 000", out_valid, out_last, frame_done); else passes++;
    checks++; if (out_window !== 24'h0) $display("FAIL reset_window: got %h want 000000", out_window); else passes++;
    do_reset();
    send(8'h11); send(8'h12); send(8'h13);
    out_ready = 0; #3;
    checks++; if (out_valid !== 1) $display("FAIL pre_reset_valid: got %b want 1", out_valid); else passes++;
    rst = 1; #1;
    checks++; if (out_valid !== 0 || out_window !== 24'h0 || out_last !== 0) $display("FAIL async_reset: v=%b w=%h l=%b want 0/000000/0", out_valid, out_window, out_last); else passes++;
    checks++; if (in_ready !== 1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
    @(posedge clk); #1; rst = 0; out_ready = 1;
    win_q.delete(); last_q.delete(); fd_cnt = 0; prev_hs = 0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    repeat (2) @(posedge clk); #1;
    checks++; if (win_q.size() != (PAD ? 4 : 2)) $display("FAIL post_reset_count: got %0d want %0d", win_q.size(), PAD ? 4 : 2);
    else begin
      passes++;
      checks++; if (win_q[win_q.size()-2] !== 24'h030201) $display("FAIL post_reset_win0: got %h want 030201", win_q[win_q.size()-2]); else passes++;
      checks++; if (win_q[win_q.size()-1] !== 24'h040302) $display("FAIL post_reset_win1: got %h want 040302", win_q[win_q.size()-1]); else passes++;
    end
  endtask

  task automatic test_row();
    logic [23:0] ew[4];
    logic        el[4];
    int n;
    if (PAD) begin
      ew[0] = 24'h010000; ew[1] = 24'h020100; ew[2] = 24'h030201; ew[3] = 24'h040302;
      el[0] = 0; el[1] = 0; el[2] = 0; el[3] = 1; n = 4;
    end else begin
      ew[0] = 24'h030201; ew[1] = 24'h040302; ew[2] = 0; ew[3] = 0;
      el[0] = 0; el[1] = 1; el[2] = 0; el[3] = 0; n = 2;
    end
    do_reset();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    repeat (2) @(posedge clk); #1;
    checks++; if (win_q.size() != n) $display("FAIL row_count: got %0d want %0d", win_q.size(), n); else passes++;
    for (int i = 0; i < n && i < win_q.size(); i++) begin
      checks++; if (win_q[i] !== ew[i] || last_q[i] !== el[i]) $display("FAIL row_win%0d: got %h/%b want %h/%b", i, win_q[i], last_q[i], ew[i], el[i]); else passes++;
    end
    checks++; if (fd_cnt != 0) $display("FAIL row_no_fd: got %0d want 0", fd_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    send(8'h01); send(8'h02); send(8'h03);
    out_ready = 0; in_ifmap = 8'h04; in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 0 || out_valid !== 1 || out_window !== 24'h030201)
        $display("FAIL bp_hold%0d: rdy=%b v=%b w=%h want 0/1/030201", c, in_ready, out_valid, out_window); else passes++;
    end
    @(posedge clk); #1; out_ready = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (win_q.size() != (PAD ? 4 : 2)) $display("FAIL bp_count: got %0d want %0d", win_q.size(), PAD ? 4 : 2);
    else begin
      passes++;
      checks++; if (win_q[win_q.size()-2] !== 24'h030201 || win_q[win_q.size()-1] !== 24'h040302)
        $display("FAIL bp_order: got %h,%h want 030201,040302", win_q[win_q.size()-2], win_q[win_q.size()-1]); else passes++;
    end
  endtask

  task automatic test_frame();
    do_reset();
    in_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      in_ifmap = 8'(i); @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (4) @(posedge clk); #1;
    checks++; if (fd_cnt != 1) $display("FAIL frame_fd_count: got %0d want 1", fd_cnt); else passes++;
    checks++; if (fd_after_win !== 24'h080706) $display("FAIL frame_fd_timing: window before pulse %h want 080706", fd_after_win); else passes++;
    checks++; if (win_q.size() != (PAD ? 8 : 4)) $display("FAIL frame_count: got %0d want %0d", win_q.size(), PAD ? 8 : 4); else passes++;
    checks++; if (dut.col !== '0 || dut.row !== '0) $display("FAIL frame_pos: col=%0d row=%0d want 0/0", dut.col, dut.row); else passes++;
  endtask

  task automatic test_random();
    logic [7:0]  bytes[24];
    logic [23:0] exp_q[$];
    logic [23:0] w;
    int c, mism, done;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      bytes[n] = 8'($urandom);
      c = n % ROW_W;
      if (PAD || c >= K - 1) begin
        for (int j = 0; j < K; j++) begin
          int idx = c - (K - 1) + j;
          w[8*j +: 8] = (idx < 0) ? 8'h00 : bytes[n - c + idx];
        end
        exp_q.push_back(w);
      end
    end
    done = 0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1; send(bytes[n]);
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = 1'($urandom); end
      end
    join
    out_ready = 1;
    repeat (4) @(posedge clk); #1;
    checks++; if (win_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", win_q.size(), exp_q.size()); else passes++;
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < win_q.size(); i++)
      if (win_q[i] !== exp_q[i]) begin
        if (mism == 0) $display("FAIL rand_win%0d: got %h want %h", i, win_q[i], exp_q[i]);
        mism++;
      end
    checks++; if (mism != 0) $display("FAIL rand_seq: %0d windows differ, want 0", mism); else passes++;
    checks++; if (fd_cnt != 3) $display("FAIL rand_fd: got %0d want 3", fd_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_row();
    test_backpressure();
    test_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end
endmodule
